// File: rtl/seqdet_101_word_ctrl.sv
// Word-level controller for a 1-0-1 Moore detector: serialises words MSB-first, counts hits per word.
// Optional total-hit interrupt enabled by defining SEQDET_IRQ_EN.
module seqdet_101_word_ctrl #(
   parameter int W      = 8,
   parameter int TOT_W  = 16,
   parameter int THRESH = 4,
   localparam int CW    = $clog2(W + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   output logic          det_x,
   output logic          det_rst_n,
   input  logic          det_y,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [CW-1:0] out_count,
   input  logic          irq_clr,
   output logic          irq
);

   localparam int BCW = $clog2(W);
   localparam logic [BCW-1:0] BC_FIRST = BCW'(W - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, RESP} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    sreg_q, sreg_d;
   logic [BCW-1:0]  bit_cnt_q, bit_cnt_d;
   logic [CW-1:0]   hit_cnt_q, hit_cnt_d;
   logic [CW-1:0]   out_count_q, out_count_d;
   logic            det_x_q, det_x_d;
   logic            det_rst_n_q, det_rst_n_d;
   logic            in_ready_q, in_ready_d;
   logic            out_valid_q, out_valid_d;
   logic [CW-1:0]   final_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         sreg_q      <= '0;
         bit_cnt_q   <= '0;
         hit_cnt_q   <= '0;
         out_count_q <= '0;
         det_x_q     <= 1'b0;
         det_rst_n_q <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sreg_q      <= sreg_d;
         bit_cnt_q   <= bit_cnt_d;
         hit_cnt_q   <= hit_cnt_d;
         out_count_q <= out_count_d;
         det_x_q     <= det_x_d;
         det_rst_n_q <= det_rst_n_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   // det_x is registered, so the next bit is taken from sreg one cycle ahead of its use.
   always_comb begin
      state_d     = state_q;
      sreg_d      = sreg_q;
      bit_cnt_d   = bit_cnt_q;
      hit_cnt_d   = hit_cnt_q;
      out_count_d = out_count_q;
      det_x_d     = 1'b0;
      det_rst_n_d = 1'b0;
      in_ready_d  = 1'b0;
      out_valid_d = 1'b0;
      final_cnt   = hit_cnt_q + {{(CW-1){1'b0}}, det_y};
      case (state_q)
         IDLE: begin
            in_ready_d = 1'b1;
            if (in_valid && in_ready_q) begin
               sreg_d      = {in_data[W-2:0], 1'b0};
               det_x_d     = in_data[W-1];
               det_rst_n_d = 1'b1;
               bit_cnt_d   = BC_FIRST;
               hit_cnt_d   = '0;
               in_ready_d  = 1'b0;
               state_d     = SHIFT;
            end
         end
         SHIFT: begin
            det_rst_n_d = 1'b1;
            // det_y in the first shift cycle still shows the detector's reset state.
            if (bit_cnt_q != BC_FIRST) hit_cnt_d = final_cnt;
            if (bit_cnt_q == '0) begin
               state_d = DRAIN;
            end else begin
               det_x_d   = sreg_q[W-1];
               sreg_d    = {sreg_q[W-2:0], 1'b0};
               bit_cnt_d = bit_cnt_q - 1'b1;
            end
         end
         DRAIN: begin
            hit_cnt_d   = final_cnt;
            out_count_d = final_cnt;
            out_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            if (out_ready) begin
               in_ready_d = 1'b1;
               state_d    = IDLE;
            end else begin
               out_valid_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_count = out_count_q;
   assign det_x     = det_x_q;
   assign det_rst_n = det_rst_n_q;

`ifdef SEQDET_IRQ_EN
   localparam logic [TOT_W-1:0] THRESH_V = TOT_W'(THRESH);

   logic [TOT_W-1:0] tot_q, tot_d;
   logic             irq_q, irq_d;
   logic [TOT_W:0]   tot_sum;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tot_q <= '0;
         irq_q <= 1'b0;
      end else begin
         tot_q <= tot_d;
         irq_q <= irq_d;
      end
   end

   // Saturating accumulate at DRAIN; a clear in the same cycle takes priority.
   always_comb begin
      tot_d   = tot_q;
      irq_d   = irq_q;
      tot_sum = '0;
      if (state_q == DRAIN) begin
         tot_sum = {1'b0, tot_q} + (TOT_W+1)'(final_cnt);
         tot_d   = tot_sum[TOT_W] ? '1 : tot_sum[TOT_W-1:0];
      end
      if (tot_d >= THRESH_V) irq_d = 1'b1;
      if (irq_clr) begin
         tot_d = '0;
         irq_d = 1'b0;
      end
   end

   assign irq = irq_q;
`else
   logic unused_irq_clr;
   assign unused_irq_clr = irq_clr;
   assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_seqdet_101_word_ctrl.sv
// Bench for seqdet_101_word_ctrl: a behavioural 1-0-1 detector closes the loop, hit counts
// are predicted from the word's bit pattern.
module tb_seqdet_101_word_ctrl;

   localparam int W      = 8;
   localparam int TOT_W  = 16;
   localparam int THRESH = 4;
   localparam int CW     = $clog2(W + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          det_x;
   logic          det_rst_n;
   logic          det_y;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] out_count;
   logic          irq_clr;
   logic          irq;

   int n_cmp  = 0;
   int n_fail = 0;
   int exp_tot = 0;
   int exp_irq = 0;

   always #5 clk = ~clk;

   seqdet_101_word_ctrl #(.W(W), .TOT_W(TOT_W), .THRESH(THRESH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .det_x(det_x), .det_rst_n(det_rst_n), .det_y(det_y),
      .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
      .irq_clr(irq_clr), .irq(irq)
   );

   // Behavioural Moore detector: y is high when the last three bits seen were 1,0,1.
   logic [2:0] hist;
   always @(posedge clk or negedge det_rst_n) begin
      if (!det_rst_n) hist <= 3'b000;
      else            hist <= {hist[1:0], det_x};
   end
   assign det_y = (hist == 3'b101);

   function automatic int ref_count(input logic [W-1:0] d);
      int n;
      n = 0;
      for (int p = W - 1; p >= 2; p--)
         if (d[p] && !d[p-1] && d[p-2]) n++;
      return n;
   endfunction

   function automatic void model_word(input int cnt);
`ifdef SEQDET_IRQ_EN
      exp_tot = exp_tot + cnt;
      if (exp_tot > (1 << TOT_W) - 1) exp_tot = (1 << TOT_W) - 1;
      if (exp_tot >= THRESH) exp_irq = 1;
`else
      exp_tot = exp_tot + 0 * cnt;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the controller idle.
   task automatic run_word(input logic [W-1:0] d, input int stall);
      int lat;
      int cnt;
      cnt = ref_count(d);
      check("idle_in_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = W'($urandom);
      lat = 0;
      while (!out_valid && lat < W + 10) begin
         if (lat == 1) begin
            check("shift_in_ready", in_ready, 0);
            check("shift_det_rst_n", det_rst_n, 1);
         end
         @(negedge clk);
         lat++;
      end
      model_word(cnt);
      check("latency", lat, W + 1);
      check("count", out_count, cnt);
      check("resp_in_ready", in_ready, 0);
      check("resp_det_rst_n", det_rst_n, 0);
      check("irq_after_word", irq, exp_irq);
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         check("stall_valid", out_valid, 1);
         check("stall_count", out_count, cnt);
         check("stall_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("release_valid", out_valid, 0);
      check("release_in_ready", in_ready, 1);
   endtask

   task automatic check_reset_outputs();
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_count", out_count, 0);
      check("rst_det_x", det_x, 0);
      check("rst_det_rst_n", det_rst_n, 0);
      check("rst_irq", irq, 0);
   endtask

   initial begin
      rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; irq_clr = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs();
      rst = 1'b1;
      @(negedge clk);

      run_word(8'b1010_0000, 0);
      run_word(8'b1010_1010, 0);
      run_word(8'h00, 0);
      run_word(8'b0000_0101, 0);
      run_word(8'b0000_0010, 0);
      run_word(8'b1000_0000, 0);
      run_word(8'b1011_0101, 5);
      run_word(8'hFF, 1);

      // Reset during SHIFT cycle 4 discards the word.
      in_valid = 1'b1;
      in_data  = 8'b1010_1010;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      exp_tot = 0;
      exp_irq = 0;
      #1;
      check_reset_outputs();
      @(negedge clk);
      rst = 1'b1;
      begin
         int seen;
         seen = 0;
         repeat (W + 5) begin
            @(negedge clk);
            if (out_valid) seen = 1;
         end
         check("no_valid_after_reset", seen, 0);
      end
      run_word(8'b1010_0101, 0);

      // Total-hit interrupt scenario.
      irq_clr = 1'b1;
      @(negedge clk);
      irq_clr = 1'b0;
      exp_tot = 0;
      exp_irq = 0;
      check("irq_cleared", irq, 0);
      run_word(8'b1010_1000, 0);
      run_word(8'b1010_1000, 0);
      irq_clr = 1'b1;
      @(negedge clk);
      irq_clr = 1'b0;
      exp_tot = 0;
      exp_irq = 0;
      check("irq_after_clr", irq, 0);

      for (int i = 0; i < 25; i++) run_word(W'($urandom), int'($urandom_range(0, 2)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
